shift_unit: RTL and testbench



---
 rtl/shift_unit.sv | 118 +++++++++++
 tb/tb_shift_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// Multi-cycle shifter/rotator (LSR, ASR, LSL, ROR) with valid/ready handshakes.
// Define SHIFT_UNIT_BARREL_EN to compute the whole shift in one step at accept time.
module shift_unit #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_carry
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_reg;
  logic             carry_reg;
  logic             accept;

  // One position of shift per mode; result is {carry_out, data}.
  function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] d,
                                                input logic [1:0]       m);
    logic [WIDTH:0] r;
    case (m)
      2'b00:   r = {d[0], 1'b0, d[WIDTH-1:1]};
      2'b01:   r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      2'b10:   r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
      default: r = {d[0], d[0], d[WIDTH-1:1]};
    endcase
    return r;
  endfunction

`ifdef SHIFT_UNIT_BARREL_EN
  // Unrolled chain of single steps so the carry matches the iterative path exactly.
  function automatic logic [WIDTH:0] barrel_shift(input logic [WIDTH-1:0]   d,
                                                  input logic [SHAMT_W-1:0] k,
                                                  input logic [1:0]         m);
    logic [WIDTH:0] r;
    r = {1'b0, d};
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(k)) r = shift_step(r[WIDTH-1:0], m);
    end
    return r;
  endfunction
`else
  logic [SHAMT_W-1:0] cnt_reg;
  logic [1:0]         mode_reg;
`endif

  assign accept    = in_valid && (state == IDLE);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = data_reg;
  assign out_carry = carry_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef SHIFT_UNIT_BARREL_EN
          state_nxt = DONE;
`else
          state_nxt = (in_shamt == '0) ? DONE : SHIFT;
`endif
        end
      end
      SHIFT: begin
`ifdef SHIFT_UNIT_BARREL_EN
        state_nxt = DONE;
`else
        if (cnt_reg == SHAMT_W'(1)) state_nxt = DONE;
`endif
      end
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      carry_reg <= 1'b0;
`ifndef SHIFT_UNIT_BARREL_EN
      cnt_reg   <= '0;
      mode_reg  <= '0;
`endif
    end else if (accept) begin
`ifdef SHIFT_UNIT_BARREL_EN
      {carry_reg, data_reg} <= barrel_shift(in_data, in_shamt, in_mode);
`else
      data_reg  <= in_data;
      carry_reg <= 1'b0;
      cnt_reg   <= in_shamt;
      mode_reg  <= in_mode;
`endif
    end
`ifndef SHIFT_UNIT_BARREL_EN
    else if (state == SHIFT) begin
      {carry_reg, data_reg} <= shift_step(data_reg, mode_reg);
      cnt_reg               <= cnt_reg - SHAMT_W'(1);
    end
`endif
  end

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: WIDTH=4 and WIDTH=8 instances driven from a vector table
// plus hand-written reset, backpressure and next-accept sequences.
module tb_shift_unit;

  logic       clk;
  logic       rst_n;

  logic       iv4, ir4, ov4, or4, oc4;
  logic [3:0] id4, od4;
  logic [1:0] is4, im4;

  logic       iv8, ir8, ov8, or8, oc8;
  logic [7:0] id8, od8;
  logic [2:0] is8;
  logic [1:0] im8;

  int checks = 0;
  int errors = 0;

  shift_unit #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4), .in_data(id4), .in_shamt(is4), .in_mode(im4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_carry(oc4)
  );

  shift_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_shamt(is8), .in_mode(im8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_carry(oc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         w4;
    logic [7:0] d;
    logic [2:0] k;
    logic [1:0] m;
    logic [7:0] ed;
    logic       ec;
    string      nm;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] k);
`ifdef SHIFT_UNIT_BARREL_EN
    return 0;
`else
    return int'(k);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand, scramble the inputs while it is in flight, wait and check, then drain.
  task automatic run_vec(input vec_t v);
    int lat;
    if (v.w4) begin
      chk({v.nm, "_in_ready"}, 32'(ir4), 32'd1);
      id4 = v.d[3:0]; is4 = v.k[1:0]; im4 = v.m; iv4 = 1'b1;
    end else begin
      chk({v.nm, "_in_ready"}, 32'(ir8), 32'd1);
      id8 = v.d; is8 = v.k; im8 = v.m; iv8 = 1'b1;
    end
    step();
    iv4 = 1'b0; iv8 = 1'b0;
    id4 = ~v.d[3:0]; is4 = ~v.k[1:0]; im4 = ~v.m;
    id8 = ~v.d;      is8 = ~v.k;      im8 = ~v.m;
    lat = 0;
    while (!(v.w4 ? ov4 : ov8) && lat < 40) begin
      step();
      lat++;
    end
    chk({v.nm, "_latency"}, 32'(lat), 32'(exp_lat(v.k)));
    if (v.w4) begin
      chk({v.nm, "_data"},  32'(od4), 32'(v.ed[3:0]));
      chk({v.nm, "_carry"}, 32'(oc4), 32'(v.ec));
      or4 = 1'b1;
    end else begin
      chk({v.nm, "_data"},  32'(od8), 32'(v.ed));
      chk({v.nm, "_carry"}, 32'(oc8), 32'(v.ec));
      or8 = 1'b1;
    end
    step();
    or4 = 1'b0; or8 = 1'b0;
    chk({v.nm, "_drained"}, 32'(v.w4 ? {ov4, ir4} : {ov8, ir8}), 32'b01);
  endtask

  initial begin
    int   lat;
    logic stale;

    vecs[0]  = '{1'b1, 8'h0A, 3'd1, 2'b01, 8'h0D, 1'b0, "w4_asr1"};
    vecs[1]  = '{1'b1, 8'h0A, 3'd1, 2'b00, 8'h05, 1'b0, "w4_lsr1"};
    vecs[2]  = '{1'b1, 8'h0A, 3'd1, 2'b10, 8'h04, 1'b1, "w4_lsl1"};
    vecs[3]  = '{1'b1, 8'h0A, 3'd1, 2'b11, 8'h05, 1'b0, "w4_ror1"};
    vecs[4]  = '{1'b1, 8'h0A, 3'd3, 2'b11, 8'h05, 1'b0, "w4_ror3"};
    vecs[5]  = '{1'b1, 8'h06, 3'd3, 2'b10, 8'h00, 1'b1, "w4_lsl3"};
    vecs[6]  = '{1'b0, 8'h96, 3'd3, 2'b01, 8'hF2, 1'b1, "w8_asr3"};
    vecs[7]  = '{1'b0, 8'hA5, 3'd0, 2'b11, 8'hA5, 1'b0, "w8_ror0"};
    vecs[8]  = '{1'b0, 8'h81, 3'd7, 2'b11, 8'h03, 1'b0, "w8_ror7"};
    vecs[9]  = '{1'b0, 8'h96, 3'd7, 2'b00, 8'h01, 1'b0, "w8_lsr7"};
    vecs[10] = '{1'b0, 8'h96, 3'd2, 2'b10, 8'h58, 1'b0, "w8_lsl2"};
    vecs[11] = '{1'b0, 8'h80, 3'd7, 2'b01, 8'hFF, 1'b0, "w8_asr7"};
    vecs[12] = '{1'b0, 8'h7F, 3'd4, 2'b01, 8'h07, 1'b1, "w8_asr4"};
    vecs[13] = '{1'b0, 8'h01, 3'd1, 2'b11, 8'h80, 1'b1, "w8_ror1"};

    rst_n = 1'b0;
    iv4 = 1'b0; id4 = '0; is4 = '0; im4 = '0; or4 = 1'b0;
    iv8 = 1'b0; id8 = '0; is8 = '0; im8 = '0; or8 = 1'b0;
    repeat (2) step();
    chk("rst_w4_outputs", 32'({ov4, od4, oc4, ir4}), 32'b0_0000_0_1);
    chk("rst_w8_outputs", 32'({ov8, od8, oc8, ir8}), 32'b0_00000000_0_1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a k=3 operation on the WIDTH=4 unit.
    id4 = 4'b1010; is4 = 2'd3; im4 = 2'b00; iv4 = 1'b1;
    step();
    iv4 = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov4), 32'd0);
    chk("midrst_out_data",  32'(od4), 32'd0);
    chk("midrst_out_carry", 32'(oc4), 32'd0);
    chk("midrst_in_ready",  32'(ir4), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      step();
      if (ov4) stale = 1'b1;
    end
    chk("midrst_no_stale", 32'(stale), 32'd0);
    chk("midrst_idle", 32'(ir4), 32'd1);

    // Backpressure on the WIDTH=8 unit with the next operand already waiting.
    id8 = 8'h96; is8 = 3'd3; im8 = 2'b01; iv8 = 1'b1;
    step();
    id8 = 8'h01; is8 = 3'd1; im8 = 2'b11;
    lat = 0;
    while (!ov8 && lat < 40) begin
      step();
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'(exp_lat(3'd3)));
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold_data",  32'(od8), 32'hF2);
      chk("bp_hold_carry", 32'(oc8), 32'd1);
      chk("bp_hold_flags", 32'({ov8, ir8}), 32'b10);
    end
    or8 = 1'b1;
    step();
    or8 = 1'b0;
    chk("bp_release_flags", 32'({ov8, ir8}), 32'b01);
    step();
    iv8 = 1'b0;
    chk("bp_next_accepted", 32'(ir8), 32'd0);
    lat = 1;
    while (!ov8 && lat < 40) begin
      step();
      lat++;
    end
    chk("bp_next_latency", 32'(lat - 1), 32'(exp_lat(3'd1)));
    chk("bp_next_data",  32'(od8), 32'h80);
    chk("bp_next_carry", 32'(oc8), 32'd1);
    or8 = 1'b1;
    step();
    or8 = 1'b0;
    chk("bp_next_drained", 32'({ov8, ir8}), 32'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
